// File: rtl/stump_mem_arbiter_pkg.sv
// Shared types and helpers for the Stump memory-port arbiter.
`timescale 1ns/1ps
package stump_mem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } arb_owner_e;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating increment used by the starvation counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/stump_arb_counter.sv
// Loadable 4-bit down-counter with a zero flag; times each memory access.
`timescale 1ns/1ps
module stump_arb_counter
    import stump_mem_arbiter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/stump_mem_arbiter.sv
// Shares the single Stump memory port between the CPU and a debug/DMA requester,
// sequencing each access over MEM_LAT cycles and stalling the CPU meanwhile.
`timescale 1ns/1ps
module stump_mem_arbiter
    import stump_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ren,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_wen,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    input  logic              dbg_halt,
    output logic              cpu_halted,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ren,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] STARVE_THR = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q, state_d;
    arb_owner_e       owner_q;
    logic [CNT_W-1:0] starve_cnt;
    logic             cpu_req;
    logic             grant_cpu, grant_dbg;
    logic             lat_zero;
    logic             done;

    assign cpu_req = cpu_ren | cpu_wen;
    assign done    = (state_q == ST_ACCESS) & lat_zero;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dbg_halt) begin
                    grant_dbg = dbg_req;
                end else if (cpu_req && dbg_req) begin
                    if (starve_cnt >= STARVE_THR) grant_dbg = 1'b1;
                    else                          grant_cpu = 1'b1;
                end else begin
                    grant_dbg = dbg_req;
                    grant_cpu = cpu_req;
                end
                if (grant_cpu || grant_dbg) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (lat_zero) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory-side request is captured at grant and held for the whole access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q   <= OWN_CPU;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
        end else if (grant_cpu) begin
            owner_q   <= OWN_CPU;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_wen   <= cpu_wen;
            mem_ren   <= cpu_ren & ~cpu_wen;
        end else if (grant_dbg) begin
            owner_q   <= OWN_DBG;
            mem_addr  <= dbg_addr;
            mem_wdata <= dbg_wdata;
            mem_wen   <= dbg_wen;
            mem_ren   <= ~dbg_wen;
        end else if (done) begin
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_dbg) begin
            starve_cnt <= '0;
        end else if (grant_cpu && dbg_req) begin
            starve_cnt <= sat_inc(starve_cnt);
        end
    end

    // Halt takes effect only at an access boundary: idle, or finishing a CPU access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_halted <= 1'b0;
        end else if (!dbg_halt) begin
            cpu_halted <= 1'b0;
        end else if ((state_q == ST_IDLE) || (done && (owner_q == OWN_CPU))) begin
            cpu_halted <= 1'b1;
        end
    end

    stump_arb_counter #(
        .W (CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (grant_cpu | grant_dbg),
        .load_val (LAT_LOAD),
        .dec      (state_q == ST_ACCESS),
        .zero     (lat_zero)
    );

    assign cpu_stall = cpu_req & ~(done & (owner_q == OWN_CPU));
    assign dbg_ack   = done & (owner_q == OWN_DBG);
    assign cpu_rdata = mem_rdata;
    assign dbg_rdata = mem_rdata;

endmodule

// File: tb/tb_stump_mem_arbiter.sv
// Directed scoreboard bench for stump_mem_arbiter with MEM_LAT=3, STARVE_LIMIT=4.
`timescale 1ns/1ps
module tb_stump_mem_arbiter;
    import stump_mem_arbiter_pkg::*;

    localparam int ML = 3;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_ren = 1'b0, cpu_wen = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req = 1'b0, dbg_wen = 1'b0;
    logic [15:0] dbg_addr = '0, dbg_wdata = '0;
    logic [15:0] dbg_rdata;
    logic        dbg_ack;
    logic        dbg_halt = 1'b0;
    logic        cpu_halted;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ren, mem_wen;

    always #5 clk = ~clk;

    stump_mem_arbiter #(
        .ADDR_W(16), .DATA_W(16), .MEM_LAT(ML), .STARVE_LIMIT(SL)
    ) u_dut (
        .clk(clk), .rst(rst),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_wen(dbg_wen), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .dbg_halt(dbg_halt), .cpu_halted(cpu_halted),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        ren;
        logic        wen;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    typedef struct {
        logic        is_read;
        logic [15:0] rdata;
    } resp_t;

    txn_t  cpu_jobs[$], dbg_jobs[$], exp_mem[$];
    resp_t exp_cpu[$], exp_dbg[$];
    logic [15:0] model [256];
    logic [15:0] tb_mem [256];
    logic        tb_wr [256];
    int checks = 0;
    int failures = 0;
    logic cpu_busy = 1'b0, dbg_busy = 1'b0;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h40) ? 16'hBEEF : {a ^ 8'h5C, a};
    endfunction

    // Memory model: reads combinational while mem_ren, writes on each access edge.
    assign mem_rdata = mem_ren ? (tb_wr[mem_addr[7:0]] ? tb_mem[mem_addr[7:0]]
                                                       : init_val(mem_addr[7:0])) : 16'h0000;
    always @(posedge clk) begin
        if (rst && mem_wen) begin
            tb_mem[mem_addr[7:0]] <= mem_wdata;
            tb_wr[mem_addr[7:0]]  <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic cpu_job(input logic ren, input logic wen, input logic [15:0] addr,
                           input logic [15:0] data, input bit expect_resp = 1'b1);
        txn_t  t;
        resp_t r;
        t.ren = ren; t.wen = wen; t.addr = addr; t.data = data;
        cpu_jobs.push_back(t);
        if (expect_resp) begin
            r.is_read = ren & ~wen;
            r.rdata   = model[addr[7:0]];
            exp_cpu.push_back(r);
        end
        if (wen) model[addr[7:0]] = data;
    endtask

    task automatic dbg_job(input logic wr, input logic [15:0] addr, input logic [15:0] data);
        txn_t  t;
        resp_t r;
        t.ren = ~wr; t.wen = wr; t.addr = addr; t.data = data;
        dbg_jobs.push_back(t);
        r.is_read = ~wr;
        r.rdata   = model[addr[7:0]];
        exp_dbg.push_back(r);
        if (wr) model[addr[7:0]] = data;
    endtask

    task automatic exp_txn(input logic ren, input logic wen, input logic [15:0] addr,
                           input logic [15:0] data);
        txn_t t;
        t.ren = ren; t.wen = wen; t.addr = addr; t.data = data;
        exp_mem.push_back(t);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((cpu_jobs.size() != 0 || dbg_jobs.size() != 0 || exp_mem.size() != 0 ||
                exp_cpu.size() != 0 || exp_dbg.size() != 0 || cpu_busy || dbg_busy) &&
               n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 32'(n < budget), 32'd1);
        tick();
    endtask

    // CPU agent: holds each request until a cycle with cpu_stall low, then moves on.
    initial begin
        txn_t j;
        logic fin;
        forever begin
            @(negedge clk);
            fin = cpu_busy && !cpu_stall;
            @(posedge clk);
            #1;
            if (!rst) begin
                cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_busy = 1'b0;
            end else if (fin || !cpu_busy) begin
                if (cpu_jobs.size() != 0) begin
                    j = cpu_jobs.pop_front();
                    cpu_ren = j.ren; cpu_wen = j.wen; cpu_addr = j.addr; cpu_wdata = j.data;
                    cpu_busy = 1'b1;
                end else begin
                    cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_busy = 1'b0;
                end
            end
        end
    end

    // Debug agent: holds dbg_req until dbg_ack.
    initial begin
        txn_t j;
        logic fin;
        forever begin
            @(negedge clk);
            fin = dbg_busy && dbg_ack;
            @(posedge clk);
            #1;
            if (!rst) begin
                dbg_req = 1'b0; dbg_busy = 1'b0;
            end else if (fin || !dbg_busy) begin
                if (dbg_jobs.size() != 0) begin
                    j = dbg_jobs.pop_front();
                    dbg_req = 1'b1; dbg_wen = j.wen; dbg_addr = j.addr; dbg_wdata = j.data;
                    dbg_busy = 1'b1;
                end else begin
                    dbg_req = 1'b0; dbg_busy = 1'b0;
                end
            end
        end
    end

    // Output monitor: pops the scoreboard whenever the DUT produces something.
    initial begin
        int    mem_run = 0;
        txn_t  cur;
        resp_t r;
        cur = '{ren: 1'b0, wen: 1'b0, addr: 16'h0, data: 16'h0};
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_run = 0;
            end else begin
                if (mem_ren || mem_wen) begin
                    if (mem_run == 0) begin
                        check("mem_txn_expected", 32'(exp_mem.size() != 0), 32'd1);
                        if (exp_mem.size() != 0) begin
                            cur = exp_mem.pop_front();
                            check("mem_addr", 32'(mem_addr), 32'(cur.addr));
                            check("mem_ren", 32'(mem_ren), 32'(cur.ren));
                            check("mem_wen", 32'(mem_wen), 32'(cur.wen));
                            if (cur.wen) check("mem_wdata", 32'(mem_wdata), 32'(cur.data));
                        end
                    end else begin
                        check("mem_addr_hold", 32'(mem_addr), 32'(cur.addr));
                        check("mem_wen_hold", 32'(mem_wen), 32'(cur.wen));
                    end
                    mem_run++;
                end else if (mem_run != 0) begin
                    check("mem_access_len", 32'(mem_run), 32'(ML));
                    mem_run = 0;
                end
                if (dbg_ack) begin
                    check("dbg_ack_expected", 32'(exp_dbg.size() != 0), 32'd1);
                    if (exp_dbg.size() != 0) begin
                        r = exp_dbg.pop_front();
                        if (r.is_read) check("dbg_rdata", 32'(dbg_rdata), 32'(r.rdata));
                    end
                end
                if (cpu_busy && !cpu_stall) begin
                    check("cpu_done_expected", 32'(exp_cpu.size() != 0), 32'd1);
                    if (exp_cpu.size() != 0) begin
                        r = exp_cpu.pop_front();
                        if (r.is_read) check("cpu_rdata", 32'(cpu_rdata), 32'(r.rdata));
                    end
                end
            end
        end
    end

    initial begin
        int stall_cycles;
        bit released;

        for (int i = 0; i < 256; i++) model[i] = init_val(8'(i));
        tick();
        tick();

        // Reset state
        check("rst_mem_ren", 32'(mem_ren), 32'd0);
        check("rst_mem_wen", 32'(mem_wen), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        check("rst_cpu_halted", 32'(cpu_halted), 32'd0);
        check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        rst = 1'b1;
        tick();

        // Reset in the 2nd ACCESS cycle of a CPU read abandons it
        cpu_job(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0);
        exp_txn(1'b1, 1'b0, 16'h0008, 16'h0000);
        tick(); tick(); tick();
        check("t1_mid_access_ren", 32'(mem_ren), 32'd1);
        rst = 1'b0;
        #1;
        check("t1_mem_ren_async", 32'(mem_ren), 32'd0);
        check("t1_state_idle", 32'(u_dut.state_q), 32'(ST_IDLE));
        check("t1_dbg_ack", 32'(dbg_ack), 32'd0);
        tick(); tick();
        rst = 1'b1;
        wait_drain("t1", 50);

        // CPU read of 0x0040 stalls for MEM_LAT cycles and returns 0xBEEF
        cpu_job(1'b1, 1'b0, 16'h0040, 16'h0000);
        exp_txn(1'b1, 1'b0, 16'h0040, 16'h0000);
        stall_cycles = 0;
        released = 1'b0;
        for (int i = 0; i < 20 && !released; i++) begin
            tick();
            if (cpu_ren && cpu_stall) stall_cycles++;
            else if (cpu_ren) begin
                released = 1'b1;
                check("t2_cpu_rdata", 32'(cpu_rdata), 32'h0000BEEF);
            end
        end
        check("t2_released", 32'(released), 32'd1);
        check("t2_stall_cycles", 32'(stall_cycles), 32'(ML));
        wait_drain("t2", 50);

        // Both request continuously: four CPU grants then one debug grant, repeating
        for (int i = 0; i < 10; i++) cpu_job(1'b1, 1'b0, 16'(16'h0010 + i), 16'h0000);
        dbg_job(1'b0, 16'h0090, 16'h0000);
        dbg_job(1'b0, 16'h0091, 16'h0000);
        for (int i = 0; i < 4; i++) exp_txn(1'b1, 1'b0, 16'(16'h0010 + i), 16'h0000);
        exp_txn(1'b1, 1'b0, 16'h0090, 16'h0000);
        for (int i = 4; i < 8; i++) exp_txn(1'b1, 1'b0, 16'(16'h0010 + i), 16'h0000);
        exp_txn(1'b1, 1'b0, 16'h0091, 16'h0000);
        for (int i = 8; i < 10; i++) exp_txn(1'b1, 1'b0, 16'(16'h0010 + i), 16'h0000);
        wait_drain("t3", 200);
        check("t3_starve_cleared", 32'(u_dut.starve_cnt), 32'd0);

        // Debug write 0x1234 to 0x00FF amid CPU traffic, then read it back both ways
        for (int i = 0; i < 3; i++) begin
            cpu_job(1'b1, 1'b0, 16'(16'h0030 + i), 16'h0000);
            exp_txn(1'b1, 1'b0, 16'(16'h0030 + i), 16'h0000);
        end
        tick(); tick();
        dbg_job(1'b1, 16'h00FF, 16'h1234);
        exp_txn(1'b0, 1'b1, 16'h00FF, 16'h1234);
        wait_drain("t4_write", 100);
        dbg_job(1'b0, 16'h00FF, 16'h0000);
        exp_txn(1'b1, 1'b0, 16'h00FF, 16'h0000);
        wait_drain("t4_dbg_read", 50);
        cpu_job(1'b1, 1'b0, 16'h00FF, 16'h0000);
        exp_txn(1'b1, 1'b0, 16'h00FF, 16'h0000);
        wait_drain("t4_cpu_read", 50);

        // dbg_halt during a CPU access: CPU finishes, next CPU request waits, debug served
        cpu_job(1'b1, 1'b0, 16'h0050, 16'h0000);
        cpu_job(1'b1, 1'b0, 16'h0051, 16'h0000);
        exp_txn(1'b1, 1'b0, 16'h0050, 16'h0000);
        exp_txn(1'b1, 1'b0, 16'h00A0, 16'h0000);
        exp_txn(1'b1, 1'b0, 16'h0051, 16'h0000);
        tick(); tick();
        dbg_halt = 1'b1;
        tick(); tick();
        check("t5_halted_not_yet", 32'(cpu_halted), 32'd0);
        tick();
        check("t5_halted_set", 32'(cpu_halted), 32'd1);
        check("t5_cpu_stalled", 32'(cpu_stall), 32'd1);
        check("t5_no_mem_ren", 32'(mem_ren), 32'd0);
        dbg_job(1'b0, 16'h00A0, 16'h0000);
        repeat (6) tick();
        check("t5_dbg_served", 32'(exp_dbg.size()), 32'd0);
        check("t5_cpu_still_stalled", 32'(cpu_stall), 32'd1);
        check("t5_still_halted", 32'(cpu_halted), 32'd1);
        dbg_halt = 1'b0;
        tick();
        check("t5_halt_cleared", 32'(cpu_halted), 32'd0);
        check("t5_cpu_granted", 32'(mem_ren), 32'd1);
        check("t5_cpu_addr", 32'(mem_addr), 32'h00000051);
        wait_drain("t5", 50);

        // cpu_ren and cpu_wen together: write only
        cpu_job(1'b1, 1'b1, 16'h0020, 16'h5A5A);
        exp_txn(1'b0, 1'b1, 16'h0020, 16'h5A5A);
        cpu_job(1'b1, 1'b0, 16'h0020, 16'h0000);
        exp_txn(1'b1, 1'b0, 16'h0020, 16'h0000);
        wait_drain("t6", 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
